// File: rtl/crc_seq_pkg.sv
// Shared types and default sizing for the CRC byte sequencer.
package crc_seq_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_CRC_BITS  = 8;
  localparam int DEF_TIMEOUT   = 31;

  // Shared bit counter must index the wider of the two serial fields.
  function automatic int cnt_width(input int data_bits, input int crc_bits);
    int m;
    m = (data_bits > crc_bits) ? data_bits : crc_bits;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_DATA_BITS, DEF_CRC_BITS);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    WAIT_V,
    COLLECT,
    HOLD
  } state_t;

endpackage

// File: rtl/crc_byte_sequencer.sv
// Feeds one byte per pass into the serial CRC engine and deserialises the
// engine's CRC output into a parallel result with a valid/ready handshake.
module crc_byte_sequencer
  import crc_seq_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int CRC_BITS  = DEF_CRC_BITS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] IN_DATA,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic                 ENG_RST_N,
  output logic                 ENG_ACTIVE,
  output logic                 ENG_DATA,
  input  logic                 ENG_CRC_OUT,
  input  logic                 ENG_VALID,
  output logic [CRC_BITS-1:0]  CRC_RESULT,
  output logic                 RESULT_VALID,
  input  logic                 RESULT_READY,
  output logic                 BUSY,
  output logic                 TIMEOUT_ERR
);

  localparam int CW = cnt_width(DATA_BITS, CRC_BITS);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] COLL_LAST  = CW'(CRC_BITS - 1);
  localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT - 1);

  state_t               state;
  logic [DATA_BITS-1:0] latched;
  logic [CW-1:0]        cnt;
  logic [7:0]           tcnt;

  // Outputs are registered, so each transition loads the values that the
  // destination state presents during its first cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      latched      <= '0;
      cnt          <= '0;
      tcnt         <= '0;
      IN_READY     <= 1'b0;
      ENG_RST_N    <= 1'b0;
      ENG_ACTIVE   <= 1'b0;
      ENG_DATA     <= 1'b0;
      CRC_RESULT   <= '0;
      RESULT_VALID <= 1'b0;
      BUSY         <= 1'b0;
      TIMEOUT_ERR  <= 1'b0;
    end else begin
      TIMEOUT_ERR <= 1'b0;
      case (state)
        IDLE: begin
          ENG_RST_N <= 1'b1;
          IN_READY  <= 1'b1;
          if (IN_VALID && IN_READY) begin
            latched   <= IN_DATA;
            IN_READY  <= 1'b0;
            BUSY      <= 1'b1;
            ENG_RST_N <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          ENG_RST_N  <= 1'b1;
          ENG_ACTIVE <= 1'b1;
          ENG_DATA   <= latched[0];
          cnt        <= '0;
          state      <= SHIFT;
        end
        SHIFT: begin
          // cnt names the bit currently on ENG_DATA; preload the next one.
          if (cnt == SHIFT_LAST) begin
            ENG_ACTIVE <= 1'b0;
            ENG_DATA   <= 1'b0;
            tcnt       <= '0;
            state      <= WAIT_V;
          end else begin
            ENG_DATA <= latched[cnt + CW'(1)];
            cnt      <= cnt + CW'(1);
          end
        end
        WAIT_V: begin
          if (ENG_VALID) begin
            cnt   <= '0;
            state <= COLLECT;
          end else if (tcnt == TO_LAST) begin
            TIMEOUT_ERR <= 1'b1;
            BUSY        <= 1'b0;
            IN_READY    <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        COLLECT: begin
          CRC_RESULT[cnt] <= ENG_CRC_OUT;
          if (cnt == COLL_LAST) begin
            RESULT_VALID <= 1'b1;
            state        <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (RESULT_READY) begin
            RESULT_VALID <= 1'b0;
            BUSY         <= 1'b0;
            IN_READY     <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
